// File: rtl/counter_updown_sched_if.sv
// Requester-side bundle for counter_updown_sched.
// Two independent requesters, each with a valid/ready handshake that carries a
// direction (1 = up, 0 = down) and a step count.
//   master : requester side (drives valid, dir, steps; receives ready)
//   slave  : scheduler side (receives valid, dir, steps; drives ready)
interface counter_updown_sched_if #(
  parameter int unsigned STEP_W = 3
);
  logic              req0_valid;
  logic              req0_dir;
  logic [STEP_W-1:0] req0_steps;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_dir;
  logic [STEP_W-1:0] req1_steps;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_dir, req0_steps,
    output req1_valid, req1_dir, req1_steps,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_dir, req0_steps,
    input  req1_valid, req1_dir, req1_steps,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/counter_updown_sched.sv
// Round-robin scheduler driving a 2-bit up/down counter.
// Two requesters submit {dir, steps} commands; the winner's command is run one
// step per cycle, then a one-cycle DONE state signals completion.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   req      requester handshakes (counter_updown_sched_if.slave)
//   cnt_en   counter step enable (high in RUN)
//   cnt_mode counter direction of the current/last command (1 = up)
//   dout     internal 2-bit count value
//   grant    requester index owning the current/last command
//   busy     command in progress (RUN or DONE)
//   done     one-cycle completion pulse
//   sat      step blocked by saturation this cycle
//
// Build option: define SATURATE_EN to make dout saturate at 3 (up) and 0 (down)
// instead of wrapping; a blocked step is still consumed and raises sat. Without
// it, dout wraps modulo 4 and sat is constant 0.
module counter_updown_sched #(
  parameter int unsigned STEP_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  counter_updown_sched_if.slave         req,
  output logic                          cnt_en,
  output logic                          cnt_mode,
  output logic [1:0]                    dout,
  output logic                          grant,
  output logic                          busy,
  output logic                          done,
  output logic                          sat
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        dout_q, dout_d;
  logic              dir_q, dir_d;
  logic              grant_q, grant_d;
  logic              prio_q, prio_d;  // requester favoured on a tie

  logic              win;
  logic              hs;
  logic              blocked;
  logic [STEP_W-1:0] win_steps;
  logic              win_dir;

  // Arbitration: on a tie the favoured requester wins, otherwise whoever is valid.
  always_comb begin
    if (req.req0_valid && req.req1_valid) begin
      win = prio_q;
    end else begin
      win = req.req1_valid;
    end
  end

  // Ready is additionally gated by reset so nothing is offered while it is asserted.
  assign req.req0_ready = (state_q == IDLE) && reset && req.req0_valid && !win;
  assign req.req1_ready = (state_q == IDLE) && reset && req.req1_valid && win;
  assign hs             = req.req0_ready || req.req1_ready;

  assign win_steps = win ? req.req1_steps : req.req0_steps;
  assign win_dir   = win ? req.req1_dir   : req.req0_dir;

`ifdef SATURATE_EN
  assign blocked = dir_q ? (dout_q == 2'd3) : (dout_q == 2'd0);
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    dir_d   = dir_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          dir_d   = win_dir;
          rem_d   = win_steps;
          grant_d = win;
          prio_d  = !win;
          state_d = (win_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // 2-bit arithmetic wraps naturally (3->0 up, 0->3 down).
        if (!blocked) begin
          dout_d = dir_q ? (dout_q + 2'd1) : (dout_q - 2'd1);
        end
        rem_d = rem_q - STEP_W'(1);
        if (rem_q == STEP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dout_q  <= 2'b00;
      dir_q   <= 1'b0;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  assign cnt_en   = (state_q == RUN);
  assign sat      = cnt_en && blocked;
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign cnt_mode = dir_q;
  assign dout     = dout_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_counter_updown_sched.sv
// Scoreboard bench for counter_updown_sched: the driver predicts each accepted
// command's cycle-by-cycle outputs and queues them; the monitor pops one entry
// per RUN/DONE cycle and compares.
module tb_counter_updown_sched;

  localparam int unsigned STEP_W = 3;
`ifdef SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cnt_en, cnt_mode, grant, busy, done, sat;
  logic [1:0] dout;

  counter_updown_sched_if #(.STEP_W(STEP_W)) req ();

  counter_updown_sched #(.STEP_W(STEP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cnt_en   (cnt_en),
    .cnt_mode (cnt_mode),
    .dout     (dout),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_done;
    bit       mode;
    bit [1:0] dout;
    bit       sat;
    bit       grant;
  } rec_t;

  rec_t sb[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;
  int   m_dout = 0;   // model count value
  bit   m_prio = 1'b0; // model: requester that wins the next tie

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs of one accepted command: one entry per RUN cycle, then DONE.
  function automatic void push_cmd(input bit w, input bit dir, input int steps);
    rec_t r;
    bit   blk;
    for (int k = 0; k < steps; k++) begin
      blk       = SatEn && (dir ? (m_dout == 3) : (m_dout == 0));
      r.is_done = 1'b0;
      r.mode    = dir;
      r.dout    = 2'(m_dout);
      r.sat     = blk;
      r.grant   = w;
      sb.push_back(r);
      if (!blk) m_dout = dir ? (m_dout + 1) % 4 : (m_dout + 3) % 4;
    end
    r.is_done = 1'b1;
    r.mode    = dir;
    r.dout    = 2'(m_dout);
    r.sat     = 1'b0;
    r.grant   = w;
    sb.push_back(r);
    m_prio = !w;
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (cnt_en || done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got cnt_en=%0b done=%0b, expected no activity at %0t",
                     cnt_en, done, $time);
          end else begin
            mon_r = sb.pop_front();
            chk("done", done, mon_r.is_done);
            chk("cnt_en", cnt_en, !mon_r.is_done);
            chk("dout", dout, mon_r.dout);
            chk("cnt_mode", cnt_mode, mon_r.mode);
            chk("sat", sat, mon_r.sat);
            chk("grant", grant, mon_r.grant);
            chk("busy", busy, 1);
            chk("ready_while_busy", {req.req0_ready, req.req1_ready}, 0);
          end
        end else begin
          chk("idle_busy", busy, 0);
          chk("idle_sat", sat, 0);
        end
      end
    end
  end

  task automatic run_round(input bit v0, input bit d0, input int s0,
                           input bit v1, input bit d1, input int s1);
    bit pend0, pend1, first, w, dd;
    int cycles, last_n, n;
    @(posedge clk);
    #1;
    req.req0_valid = v0; req.req0_dir = d0; req.req0_steps = STEP_W'(s0);
    req.req1_valid = v1; req.req1_dir = d1; req.req1_steps = STEP_W'(s1);
    pend0 = v0; pend1 = v1; first = 1'b1; cycles = 0; last_n = 0;
    while (pend0 || pend1) begin
      @(negedge clk);
      cycles++;
      if (!(req.req0_ready || req.req1_ready)) begin
        if (cycles > 40) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout: got no ready in %0d cycles, expected a handshake", cycles);
          pend0 = 1'b0; pend1 = 1'b0;
          req.req0_valid = 1'b0; req.req1_valid = 1'b0;
        end
        continue;
      end
      w = (pend0 && pend1) ? m_prio : pend1;
      chk("ready0", req.req0_ready, !w);
      chk("ready1", req.req1_ready, w);
      if (!first) chk("handshake_gap", cycles, last_n + 2);
      n  = w ? s1 : s0;
      dd = w ? d1 : d0;
      push_cmd(w, dd, n);
      first = 1'b0; last_n = n; cycles = 0;
      @(posedge clk);
      #1;
      if (w) begin req.req1_valid = 1'b0; pend1 = 1'b0; end
      else   begin req.req0_valid = 1'b0; pend0 = 1'b0; end
    end
    repeat (last_n + 1) @(posedge clk);
  endtask

  task automatic mid_run_reset();
    int t;
    @(posedge clk);
    #1;
    req.req0_valid = 1'b1; req.req0_dir = 1'b1; req.req0_steps = STEP_W'(7);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req.req0_ready && t < 10);
    chk("mid_reset_accept", req.req0_ready, 1);
    push_cmd(1'b0, 1'b1, 7);
    @(posedge clk);
    #1;
    req.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt_en", cnt_en, 0);
    sb.delete();
    m_dout = 0;
    m_prio = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_dout", dout, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish by 300000");
    $fatal(1);
  end

  initial begin
    bit rv0, rv1;
    req.req0_valid = 1'b0; req.req0_dir = 1'b0; req.req0_steps = '0;
    req.req1_valid = 1'b0; req.req1_dir = 1'b0; req.req1_steps = '0;
    #1;
    req.req0_valid = 1'b1; req.req0_dir = 1'b1; req.req0_steps = STEP_W'(4);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_dout", dout, 0);
    chk("reset_cnt_en", cnt_en, 0);
    chk("reset_cnt_mode", cnt_mode, 0);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sat", sat, 0);
    chk("reset_ready", {req.req0_ready, req.req1_ready}, 0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", req.req0_ready, 1);
    req.req0_valid = 1'b0;

    // Ties right after reset: req0 first, then req1, next tie req0 again.
    run_round(1'b1, 1'b1, 1, 1'b1, 1'b0, 1);
    run_round(1'b1, 1'b1, 1, 1'b1, 1'b1, 1);
    mid_run_reset();
    run_round(1'b1, 1'b1, 4, 1'b0, 1'b0, 0);
    run_round(1'b0, 1'b0, 0, 1'b1, 1'b0, 3);
    run_round(1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
    run_round(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
    run_round(1'b1, 1'b1, 3, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_round(rv0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                rv1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
